// File: rtl/booth_csa_accum_if.sv
// Operand/result bundle for booth_csa_accum: operand handshake, abort, and the
// redundant (ps, pc) result handshake toward the downstream adder.
interface booth_csa_accum_if #(
    parameter int unsigned XLEN = 32
);
    localparam int unsigned ExtW = XLEN + 2;
    localparam int unsigned OutW = 2 * ExtW;

    logic            in_valid;
    logic            in_ready;
    logic [XLEN-1:0] a;
    logic [XLEN-1:0] b;
    logic            a_signed;
    logic            b_signed;
    logic            flush;
    logic            out_valid;
    logic            out_ready;
    logic [OutW-1:0] ps;
    logic [OutW-1:0] pc;
    logic            busy;

    modport master (
        output in_valid, a, b, a_signed, b_signed, flush, out_ready,
        input  in_ready, out_valid, ps, pc, busy
    );

    modport slave (
        input  in_valid, a, b, a_signed, b_signed, flush, out_ready,
        output in_ready, out_valid, ps, pc, busy
    );
endinterface

// File: rtl/booth_csa_accum.sv
// Iterative radix-4 Booth multiplier front end: one Booth digit per cycle folded into a
// carry-save (ps, pc) pair; the downstream adder resolves ps + pc with cin = 0.
module booth_csa_accum #(
    parameter int unsigned XLEN = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    booth_csa_accum_if.slave     bus
);
    localparam int unsigned ExtW = XLEN + 2;
    localparam int unsigned OutW = 2 * ExtW;
    localparam int unsigned NDig = ExtW / 2;
    localparam int unsigned CntW = $clog2(NDig + 1);
    localparam int unsigned ShW  = CntW + 1;

    typedef enum logic [1:0] {StIdle, StBusy, StDone} state_e;

    state_e          state_q, state_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic [ExtW-1:0] a_ext_q, a_ext_d;
    logic [ExtW-1:0] b_ext_q, b_ext_d;
    logic [OutW-1:0] ps_q, ps_d;
    logic [OutW-1:0] pc_q, pc_d;

    logic [ExtW:0]   b_win;
    logic [ShW-1:0]  bit_idx;
    logic [2:0]      trip;
    logic [OutW-1:0] a_se;
    logic [OutW-1:0] pp_raw;
    logic [OutW-1:0] pp;
    logic [OutW-1:0] maj;

    // b_win[0] stands in for b_ext[-1] = 0, so digit i reads b_win[2i+2:2i].
    always_comb begin
        b_win   = {b_ext_q, 1'b0};
        bit_idx = {cnt_q, 1'b0};
        trip    = b_win[bit_idx +: 3];
        a_se    = {{(OutW - ExtW){a_ext_q[ExtW-1]}}, a_ext_q};
        pp_raw  = '0;
        unique case (trip)
            3'b000, 3'b111: pp_raw = '0;
            3'b001, 3'b010: pp_raw = a_se;
            3'b011:         pp_raw = a_se << 1;
            3'b100:         pp_raw = (~(a_se << 1)) + OutW'(1);
            3'b101, 3'b110: pp_raw = (~a_se) + OutW'(1);
            default:        pp_raw = '0;
        endcase
        pp  = pp_raw << bit_idx;
        maj = (ps_q & pc_q) | (ps_q & pp) | (pc_q & pp);
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        a_ext_d = a_ext_q;
        b_ext_d = b_ext_q;
        ps_d    = ps_q;
        pc_d    = pc_q;
        if (bus.flush) begin
            // ps/pc are left stale; they are meaningless while out_valid is low.
            state_d = StIdle;
            cnt_d   = '0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (bus.in_valid) begin
                        a_ext_d = {{(ExtW - XLEN){bus.a_signed & bus.a[XLEN-1]}}, bus.a};
                        b_ext_d = {{(ExtW - XLEN){bus.b_signed & bus.b[XLEN-1]}}, bus.b};
                        ps_d    = '0;
                        pc_d    = '0;
                        cnt_d   = '0;
                        state_d = StBusy;
                    end
                end
                StBusy: begin
                    ps_d  = ps_q ^ pc_q ^ pp;
                    pc_d  = maj << 1;
                    cnt_d = cnt_q + CntW'(1);
                    if (cnt_q == CntW'(NDig - 1)) begin
                        state_d = StDone;
                    end
                end
                StDone: begin
                    if (bus.out_ready) begin
                        state_d = StIdle;
                    end
                end
                default: state_d = StIdle;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            a_ext_q <= '0;
            b_ext_q <= '0;
            ps_q    <= '0;
            pc_q    <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            a_ext_q <= a_ext_d;
            b_ext_q <= b_ext_d;
            ps_q    <= ps_d;
            pc_q    <= pc_d;
        end
    end

    assign bus.in_ready  = (state_q == StIdle);
    assign bus.out_valid = (state_q == StDone);
    assign bus.busy      = (state_q == StBusy) || (state_q == StDone);
    assign bus.ps        = ps_q;
    assign bus.pc        = pc_q;

endmodule

// File: tb/tb_booth_csa_accum.sv
// Directed-vector and corner-sequence bench for booth_csa_accum; checks latency,
// the resolved product ps + pc, stall stability, flush and asynchronous reset.
module tb_booth_csa_accum;
    logic clk;
    logic rst;

    booth_csa_accum_if #(.XLEN(32)) bus ();

    booth_csa_accum #(.XLEN(32)) u_dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic        as;
        logic        bs;
        logic [67:0] exp;
        int          stall;
    } vec_t;

    vec_t vecs[12];

    task automatic check(input string name, input logic [67:0] act, input logic [67:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [67:0] model(input logic [31:0] a, input logic [31:0] b,
                                          input logic as, input logic bs);
        logic [67:0] ae, be;
        ae = as ? {{36{a[31]}}, a} : {36'b0, a};
        be = bs ? {{36{b[31]}}, b} : {36'b0, b};
        return ae * be;
    endfunction

    task automatic drive_op(input logic [31:0] a, input logic [31:0] b,
                            input logic as, input logic bs);
        @(negedge clk);
        bus.in_valid = 1'b1;
        bus.a        = a;
        bus.b        = b;
        bus.a_signed = as;
        bus.b_signed = bs;
        @(posedge clk);
        @(negedge clk);
        bus.in_valid = 1'b0;
    endtask

    // Counts cycles from the negedge after the accept edge until out_valid.
    task automatic wait_done(output int n);
        n = 0;
        while (!bus.out_valid && n < 40) begin
            @(negedge clk);
            n++;
        end
    endtask

    task automatic run_op(input logic [31:0] a, input logic [31:0] b, input logic as,
                          input logic bs, input logic [67:0] exp, input int stall,
                          input string tag);
        int          n;
        logic [67:0] ps0, pc0;
        logic        stable;
        @(negedge clk);
        check({tag, " in_ready"}, 68'(bus.in_ready), 68'd1);
        drive_op(a, b, as, bs);
        wait_done(n);
        check({tag, " latency"}, 68'(n), 68'd17);
        check({tag, " product"}, bus.ps + bus.pc, exp);
        ps0    = bus.ps;
        pc0    = bus.pc;
        stable = 1'b1;
        for (int k = 0; k < stall; k++) begin
            @(negedge clk);
            if (bus.ps !== ps0 || bus.pc !== pc0 || bus.out_valid !== 1'b1 ||
                bus.in_ready !== 1'b0)
                stable = 1'b0;
        end
        if (stall > 0) check({tag, " stall stable"}, 68'(stable), 68'd1);
        bus.out_ready = 1'b1;
        @(negedge clk);
        bus.out_ready = 1'b0;
        check({tag, " release"}, 68'({bus.out_valid, bus.in_ready, bus.busy}), 68'b010);
    endtask

    initial begin
        int          n;
        logic        seen;
        logic [31:0] ra, rb;
        logic        ras, rbs;

        vecs[0]  = '{32'd3,        32'd5,        1'b0, 1'b0, 68'hF,                 0};
        vecs[1]  = '{32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1, 1'b1, 68'h1,                 1};
        vecs[2]  = '{32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, 1'b0, 68'hFFFFFFFE00000001,  0};
        vecs[3]  = '{32'h80000000, 32'hFFFFFFFF, 1'b1, 1'b0, 68'hF8000000080000000, 5};
        vecs[4]  = '{32'hFFFFFFFF, 32'd1,        1'b1, 1'b0, 68'hFFFFFFFFFFFFFFFFF, 0};
        vecs[5]  = '{32'h7FFFFFFF, 32'h80000000, 1'b1, 1'b1, 68'hFC000000080000000, 2};
        vecs[6]  = '{32'h80000000, 32'h80000000, 1'b1, 1'b1, 68'h4000000000000000,  0};
        vecs[7]  = '{32'd0,        32'hDEADBEEF, 1'b1, 1'b1, 68'h0,                 0};
        vecs[8]  = '{32'h00010000, 32'h00010000, 1'b0, 1'b0, 68'h100000000,         3};
        vecs[9]  = '{32'hFFFFFFFE, 32'd3,        1'b1, 1'b1, 68'hFFFFFFFFFFFFFFFFA, 0};
        vecs[10] = '{32'hFFFFFFFF, 32'h80000000, 1'b1, 1'b0, 68'hFFFFFFFFF80000000, 1};
        vecs[11] = '{32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, 1'b1, 68'hFFFFFFFFF00000001, 0};

        rst           = 1'b1;
        bus.in_valid  = 1'b0;
        bus.a         = '0;
        bus.b         = '0;
        bus.a_signed  = 1'b0;
        bus.b_signed  = 1'b0;
        bus.flush     = 1'b0;
        bus.out_ready = 1'b0;
        repeat (2) @(negedge clk);
        check("reset ps", bus.ps, 68'h0);
        check("reset pc", bus.pc, 68'h0);
        check("reset flags", 68'({bus.out_valid, bus.in_ready, bus.busy}), 68'b010);
        rst = 1'b0;

        for (int i = 0; i < 12; i++) begin
            run_op(vecs[i].a, vecs[i].b, vecs[i].as, vecs[i].bs, vecs[i].exp,
                   vecs[i].stall, $sformatf("vec%0d", i));
        end

        // Flush on the 8th BUSY cycle, with a competing in_valid.
        drive_op(32'd7, 32'd9, 1'b0, 1'b0);
        repeat (7) @(negedge clk);
        bus.flush    = 1'b1;
        bus.in_valid = 1'b1;
        bus.a        = 32'd11;
        bus.b        = 32'd13;
        @(negedge clk);
        bus.flush    = 1'b0;
        bus.in_valid = 1'b0;
        check("flush busy", 68'({bus.out_valid, bus.in_ready, bus.busy}), 68'b010);
        seen = 1'b0;
        repeat (25) begin
            @(negedge clk);
            if (bus.out_valid || bus.busy) seen = 1'b1;
        end
        check("flush no result", 68'(seen), 68'd0);
        run_op(32'd1234, 32'd5678, 1'b0, 1'b0, 68'd7006652, 0, "after flush");

        // Flush while holding a result.
        drive_op(32'd2, 32'd3, 1'b0, 1'b0);
        wait_done(n);
        check("flush done latency", 68'(n), 68'd17);
        bus.flush = 1'b1;
        @(negedge clk);
        bus.flush = 1'b0;
        check("flush done", 68'({bus.out_valid, bus.in_ready, bus.busy}), 68'b010);

        // in_valid presented in DONE alongside out_ready must not be taken.
        drive_op(32'd6, 32'd7, 1'b0, 1'b0);
        wait_done(n);
        check("done accept latency", 68'(n), 68'd17);
        check("done accept product", bus.ps + bus.pc, 68'd42);
        bus.in_valid  = 1'b1;
        bus.out_ready = 1'b1;
        bus.a         = 32'd100;
        @(negedge clk);
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        check("done no accept", 68'({bus.out_valid, bus.in_ready, bus.busy}), 68'b010);

        // Asynchronous reset mid-operation.
        drive_op(32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, 1'b0);
        repeat (5) @(negedge clk);
        rst = 1'b1;
        #1;
        check("async rst flags", 68'({bus.out_valid, bus.in_ready, bus.busy}), 68'b010);
        check("async rst ps", bus.ps, 68'h0);
        check("async rst pc", bus.pc, 68'h0);
        @(negedge clk);
        rst = 1'b0;
        run_op(32'hFFFFFFF9, 32'd6, 1'b1, 1'b0, 68'hFFFFFFFFFFFFFFFD6, 1, "after rst");

        for (int i = 0; i < 200; i++) begin
            ra  = $urandom;
            rb  = $urandom;
            ras = 1'($urandom_range(0, 1));
            rbs = 1'($urandom_range(0, 1));
            run_op(ra, rb, ras, rbs, model(ra, rb, ras, rbs), int'($urandom_range(0, 3)),
                   $sformatf("rand%0d", i));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1);
    end
endmodule
